// File: rtl/main_memory_responder_if.sv
// Request/response bundle between the cache-fill requester and the main-memory responder.
interface main_memory_responder_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_burst;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic [DWIDTH-1:0] data_out;
  logic              data_valid;
  logic [AWIDTH-1:0] resp_addr;
  logic              resp_last;

  modport master (
    output req_valid, req_write, req_burst, req_addr, req_wdata,
    input  req_ready, data_out, data_valid, resp_addr, resp_last
  );

  modport slave (
    input  req_valid, req_write, req_burst, req_addr, req_wdata,
    output req_ready, data_out, data_valid, resp_addr, resp_last
  );
endinterface

// File: rtl/main_memory_responder.sv
// Main-memory model: word array with pipelined fixed-latency reads, single writes and
// block-fill bursts issued one word per cycle.
module main_memory_responder #(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned AWIDTH      = 16,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  main_memory_responder_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** (AWIDTH - 1);
  localparam int unsigned CW    = $clog2(BLOCK_WORDS);

  typedef enum logic {IDLE, BURST} state_e;

  typedef struct packed {
    logic              valid;
    logic [DWIDTH-1:0] data;
    logic [AWIDTH-1:0] addr;
    logic              last;
  } stage_t;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] baddr_q, baddr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  stage_t            pipe_q [LATENCY];
  stage_t            stage0_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic              accept_c;
  logic              issue_valid_c;
  logic              issue_last_c;
  logic [AWIDTH-1:0] issue_addr_c;
  logic [AWIDTH-1:0] base_c;
  logic              unused_addr0_c;

  assign accept_c       = bus.req_valid & ready_q & ~rst;
  assign base_c         = bus.req_addr & ~AWIDTH'(2 * BLOCK_WORDS - 1);
  assign unused_addr0_c = bus.req_addr[0];

  // Next-state and issue decode
  always_comb begin
    state_d       = state_q;
    baddr_d       = baddr_q;
    cnt_d         = cnt_q;
    issue_valid_c = 1'b0;
    issue_last_c  = 1'b0;
    issue_addr_c  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept_c && !bus.req_write) begin
          issue_valid_c = 1'b1;
          if (bus.req_burst) begin
            issue_addr_c = base_c;
            baddr_d      = base_c + AWIDTH'(2);
            cnt_d        = CW'(1);
            state_d      = BURST;
          end else begin
            issue_addr_c = {bus.req_addr[AWIDTH-1:1], 1'b0};
            issue_last_c = 1'b1;
          end
        end
      end
      BURST: begin
        issue_valid_c = 1'b1;
        issue_addr_c  = baddr_q;
        issue_last_c  = (cnt_q == CW'(BLOCK_WORDS - 1));
        baddr_d       = baddr_q + AWIDTH'(2);
        cnt_d         = cnt_q + CW'(1);
        if (issue_last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    stage0_d.valid = issue_valid_c;
    stage0_d.data  = issue_valid_c ? mem_q[issue_addr_c[AWIDTH-1:1]] : '0;
    stage0_d.addr  = issue_valid_c ? issue_addr_c : '0;
    stage0_d.last  = issue_valid_c & issue_last_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baddr_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Invalid stages carry all-zero payload so outputs read zero without gating
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage0_d;
      for (int i = 1; i < int'(LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Array contents survive reset
  always_ff @(posedge clk) begin
    if (accept_c && bus.req_write) mem_q[bus.req_addr[AWIDTH-1:1]] <= bus.req_wdata;
  end

  assign bus.req_ready  = ready_q;
  assign bus.data_valid = pipe_q[LATENCY-1].valid;
  assign bus.data_out   = pipe_q[LATENCY-1].data;
  assign bus.resp_addr  = pipe_q[LATENCY-1].addr;
  assign bus.resp_last  = pipe_q[LATENCY-1].last;
endmodule
